iob_dma_wr_mc: RTL

Multi-channel stream-to-memory write DMA: N_CH independent AXI-Stream inputs, each programmed with a base address and word count. Transfers are split into AXI4 write bursts that never exceed MAX_BURST beats nor cross a 4 KB boundary. Channels are served round-robin, one burst at a time, over a single AXI write master. The block sits between the stream sources and the system interconnect, and supersedes the single-channel, fixed-mode write path.

---
 rtl/iob_dma_wr_mc_pkg.sv | 10 +
 rtl/iob_dma_rr_arb.sv | 27 ++
 rtl/iob_dma_wr_mc.sv | 138 +++++++++++++
 3 files changed

// File: rtl/iob_dma_wr_mc_pkg.sv
// iob_dma_wr_mc_pkg: shared FSM encoding, AXI constants and size helper for the write DMA
package iob_dma_wr_mc_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
  localparam logic [1:0] AXI_INCR = 2'b01;
  localparam logic [1:0] AXI_OKAY = 2'b00;
  localparam logic [12:0] PAGE_BYTES = 13'h1000;
  function automatic int size_log2(input int bytes);
    return $clog2(bytes);
  endfunction
endpackage

// File: rtl/iob_dma_rr_arb.sv
// iob_dma_rr_arb: N-way round-robin arbiter, first requester at or after ptr wins
module iob_dma_rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end
endmodule

// File: rtl/iob_dma_wr_mc.sv
// iob_dma_wr_mc: multi-channel stream-to-memory AXI4 write DMA, round-robin one burst at a time
module iob_dma_wr_mc
  import iob_dma_wr_mc_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 24,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk_i,
  input  logic                   cke_i,
  input  logic                   arst_n_i,
  input  logic [N_CH-1:0]        cfg_valid_i,
  input  logic [N_CH*ADDR_W-1:0] cfg_addr_i,
  input  logic [N_CH*LEN_W-1:0]  cfg_len_i,
  output logic [N_CH-1:0]        cfg_ready_o,
  input  logic [N_CH*DATA_W-1:0] tdata_i,
  input  logic [N_CH-1:0]        tvalid_i,
  output logic [N_CH-1:0]        tready_o,
  output logic [N_CH-1:0]        done_o,
  output logic [N_CH-1:0]        err_o,
  output logic [ADDR_W-1:0]      axi_awaddr_o,
  output logic [7:0]             axi_awlen_o,
  output logic [2:0]             axi_awsize_o,
  output logic [1:0]             axi_awburst_o,
  output logic                   axi_awvalid_o,
  input  logic                   axi_awready_i,
  output logic [DATA_W-1:0]      axi_wdata_o,
  output logic [DATA_W/8-1:0]    axi_wstrb_o,
  output logic                   axi_wlast_o,
  output logic                   axi_wvalid_o,
  input  logic                   axi_wready_i,
  input  logic [1:0]             axi_bresp_i,
  input  logic                   axi_bvalid_i,
  output logic                   axi_bready_o
);
  localparam int SZ = size_log2(DATA_W / 8);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'((1 << SZ) - 1);
  state_t state, state_n;
  logic [N_CH-1:0] busy, err, done, gnt, g_oh;
  logic [ADDR_W-1:0] addr [N_CH];
  logic [LEN_W-1:0] rem [N_CH];
  logic [IW-1:0] g, rr_ptr, idx;
  logic [7:0] len_q, cnt;
  logic [31:0] page_w, lim, beats_n;
  logic any, aw_hs, w_hs, b_hs, last;
  iob_dma_rr_arb #(.N(N_CH), .IW(IW)) u_arb (
    .req(busy & tvalid_i),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  // burst length is limited by remaining words, MAX_BURST and the words left in the 4 KB page
  assign page_w  = 32'((PAGE_BYTES - {1'b0, addr[idx][11:0]}) >> SZ);
  assign lim     = (page_w < 32'(MAX_BURST)) ? page_w : 32'(MAX_BURST);
  assign beats_n = (32'(rem[idx]) < lim) ? 32'(rem[idx]) : lim;
  assign last    = cnt == len_q;
  assign aw_hs   = state == S_ADDR && axi_awready_i;
  assign w_hs    = state == S_DATA && tvalid_i[g] && axi_wready_i;
  assign b_hs    = state == S_RESP && axi_bvalid_i;
  assign cfg_ready_o   = ~busy;
  assign done_o        = done;
  assign err_o         = err;
  assign tready_o      = (state == S_DATA && axi_wready_i) ? g_oh : '0;
  assign axi_awaddr_o  = addr[g];
  assign axi_awlen_o   = len_q;
  assign axi_awsize_o  = 3'(SZ);
  assign axi_awburst_o = AXI_INCR;
  assign axi_awvalid_o = state == S_ADDR;
  assign axi_wdata_o   = tdata_i[int'(g)*DATA_W +: DATA_W];
  assign axi_wstrb_o   = '1;
  assign axi_wlast_o   = state == S_DATA && last;
  assign axi_wvalid_o  = state == S_DATA && tvalid_i[g];
  assign axi_bready_o  = state == S_RESP;
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) state <= S_IDLE;
    else if (cke_i) state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = any ? S_ADDR : S_IDLE;
      S_ADDR:  state_n = aw_hs ? S_DATA : S_ADDR;
      S_DATA:  state_n = (w_hs && last) ? S_RESP : S_DATA;
      default: state_n = b_hs ? S_IDLE : S_RESP;
    endcase
  end
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      busy   <= '0;
      err    <= '0;
      done   <= '0;
      g      <= '0;
      g_oh   <= '0;
      rr_ptr <= '0;
      len_q  <= '0;
      cnt    <= '0;
      for (int c = 0; c < N_CH; c++) begin
        addr[c] <= '0;
        rem[c]  <= '0;
      end
    end else if (cke_i) begin
      done <= '0;
      if (state == S_IDLE && any) begin
        g     <= idx;
        g_oh  <= gnt;
        len_q <= 8'(beats_n - 1);
        cnt   <= '0;
      end
      if (w_hs) cnt <= cnt + 8'd1;
      if (b_hs) begin
        rr_ptr <= (int'(g) == N_CH - 1) ? '0 : g + 1'b1;
        if (axi_bresp_i == AXI_OKAY) begin
          addr[g] <= addr[g] + ADDR_W'((32'(len_q) + 1) << SZ);
          rem[g]  <= rem[g] - LEN_W'(32'(len_q) + 1);
          if (rem[g] == LEN_W'(32'(len_q) + 1)) begin
            busy[g] <= 1'b0;
            done[g] <= 1'b1;
          end
        end else begin
          err[g]  <= 1'b1;
          busy[g] <= 1'b0;
          done[g] <= 1'b1;
        end
      end
      // a config only lands on an idle channel, so it never collides with the burst above
      for (int c = 0; c < N_CH; c++)
        if (cfg_valid_i[c] && !busy[c]) begin
          addr[c] <= cfg_addr_i[c*ADDR_W +: ADDR_W] & AMASK;
          rem[c]  <= cfg_len_i[c*LEN_W +: LEN_W];
          err[c]  <= 1'b0;
          busy[c] <= |cfg_len_i[c*LEN_W +: LEN_W];
          done[c] <= ~|cfg_len_i[c*LEN_W +: LEN_W];
        end
    end
endmodule
